// File: rtl/regfile_pkg.sv
// Shared definitions for the byte-serial register-file port sequencer:
// FSM state encoding, header field positions and the address legality helper.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_HI   = 3'd1,
        WR_LO   = 3'd2,
        WR_STB  = 3'd3,
        RD_CAP  = 3'd4,
        RD_SEND = 3'd5
    } state_e;

    localparam int OP_BIT    = 7;
    localparam int ADDRA_LSB = 3;
    localparam int ADDRB_LSB = 0;
    localparam int ADDR_W    = 3;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned n);
        return ({{(32-ADDR_W){1'b0}}, a} < n);
    endfunction

endpackage

// File: rtl/regfile_port_seq.sv
// Byte-serial host port onto a register file: header + 2 data bytes per write, header -> 4 response bytes per read.
// Latency: write strobe 1 cycle after low byte; read data captured 1 cycle after header. Host stalls on either channel hold state.
module regfile_port_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_byte,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        write,
    output logic [2:0]  wrAddr,
    output logic [15:0] wrData,
    output logic [2:0]  rdAddrA,
    output logic [2:0]  rdAddrB,
    input  logic [15:0] rdDataA,
    input  logic [15:0] rdDataB,
    output logic        err
);

    state_e            state_q, state_d;
    logic              rdy_en_q;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [15:0]       data_q, data_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;

    logic cmd_fire, rsp_fire, a_ok, b_ok;
    logic unused_hdr_bit;

    assign unused_hdr_bit = cmd_byte[6];

    assign a_ok = addr_ok(addr_a_q, NUM_REGS);
    assign b_ok = addr_ok(addr_b_q, NUM_REGS);

    // rdy_en_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = rdy_en_q &&
                       (state_q == IDLE || state_q == WR_HI || state_q == WR_LO);
    assign rsp_valid = (state_q == RD_SEND);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign write    = (state_q == WR_STB) && b_ok;
    assign err      = ((state_q == WR_STB) && !b_ok) ||
                      ((state_q == RD_CAP) && !(a_ok && b_ok));
    assign wrAddr   = addr_b_q;
    assign wrData   = data_q;
    assign rdAddrA  = addr_a_q;
    assign rdAddrB  = addr_b_q;
    assign rsp_byte = shift_q[31:24];

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_d   = data_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_a_d = cmd_byte[ADDRA_LSB +: ADDR_W];
                    addr_b_d = cmd_byte[ADDRB_LSB +: ADDR_W];
                    state_d  = cmd_byte[OP_BIT] ? WR_HI : RD_CAP;
                end
            end
            WR_HI: begin
                if (cmd_fire) begin
                    data_d[15:8] = cmd_byte;
                    state_d      = WR_LO;
                end
            end
            WR_LO: begin
                if (cmd_fire) begin
                    data_d[7:0] = cmd_byte;
                    state_d     = WR_STB;
                end
            end
            WR_STB: state_d = IDLE;
            RD_CAP: begin
                shift_d = {a_ok ? rdDataA : 16'h0000, b_ok ? rdDataB : 16'h0000};
                cnt_d   = 2'd0;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                if (rsp_fire) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_q   <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_seq.sv
// Directed bench for regfile_port_seq with a behavioural 8-entry register file attached.
module tb_regfile_port_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_byte;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        write;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic [2:0]  rdAddrA, rdAddrB;
    logic [15:0] rdDataA, rdDataB;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [2:0]  last_addr;
    logic [15:0] last_data;
    logic [15:0] rf [8];

    always #5 clk = ~clk;

    regfile_port_seq #(.NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_byte(rsp_byte), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .rdDataA(rdDataA), .rdDataB(rdDataB),
        .err(err)
    );

    assign rdDataA = rf[rdAddrA];
    assign rdDataB = rf[rdAddrB];

    always @(posedge clk) if (write) rf[wrAddr] <= wrData;

    always @(negedge clk) begin
        if (write) begin
            wr_cnt++;
            last_addr = wrAddr;
            last_data = wrData;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) @(negedge clk);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_timeout", 32'd1, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rsp_timeout", 32'd1, 32'd0);
        b = rsp_byte;
        @(negedge clk);
    endtask

    task automatic read4(input logic [7:0] hdr, input logic [31:0] exp, input string tag);
        logic [7:0] b;
        send_byte(hdr, 0);
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            check(tag, {24'h0, b}, {24'h0, exp[31 - 8*i -: 8]});
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        int wr0, er0;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        rst_n = 1'b0; cmd_byte = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_write", {31'h0, write}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_rsp_byte", {24'h0, rsp_byte}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("ready_before_edge", {31'h0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'h0, cmd_ready}, 32'd1);

        // Basic write with 1-cycle strobe latency
        send_byte(8'h82, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        check("wr_strobe", {31'h0, write}, 32'd1);
        check("wr_addr", {29'h0, wrAddr}, 32'd2);
        check("wr_data", {16'h0, wrData}, 32'h0000BEEF);
        check("wr_err", {31'h0, err}, 32'd0);
        check("wr_ready_stb", {31'h0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("wr_strobe_off", {31'h0, write}, 32'd0);
        check("wr_count", wr_cnt, 32'd1);

        // Two writes then a combined read
        send_byte(8'h81, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h83, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        @(negedge clk);
        read4(8'h0B, 32'h1234ABCD, "rd_1_3");

        // Illegal write address
        wr0 = wr_cnt; er0 = err_cnt;
        send_byte(8'h86, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        check("illwr_err", {31'h0, err}, 32'd1);
        check("illwr_write", {31'h0, write}, 32'd0);
        repeat (2) @(negedge clk);
        check("illwr_wrcnt", wr_cnt - wr0, 32'd0);
        check("illwr_errcnt", err_cnt - er0, 32'd1);
        read4(8'h13, 32'hBEEFABCD, "rd_2_3");

        // Illegal read operand returns zeros
        er0 = err_cnt;
        read4(8'h0E, 32'h12340000, "rd_1_6");
        check("illrd_errcnt", err_cnt - er0, 32'd1);

        // Response stall after the 2nd byte
        send_byte(8'h0B, 0);
        recv_byte(b); check("stall_b0", {24'h0, b}, 32'h12);
        recv_byte(b); check("stall_b1", {24'h0, b}, 32'h34);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {23'h0, rsp_valid, rsp_byte}, 32'h1AB);
        end
        recv_byte(b); check("stall_b2", {24'h0, b}, 32'hAB);
        recv_byte(b); check("stall_b3", {24'h0, b}, 32'hCD);
        rsp_ready = 1'b0;
        check("stall_done", {31'h0, rsp_valid}, 32'd0);

        // Gapped cmd_valid; bit6 of the header is ignored
        send_byte(8'hC0, $urandom_range(0, 3));
        send_byte(8'hC0, $urandom_range(1, 4));
        send_byte(8'hDE, $urandom_range(1, 4));
        repeat (2) @(negedge clk);
        check("gap_addr", {29'h0, last_addr}, 32'd0);
        check("gap_data", {16'h0, last_data}, 32'h0000C0DE);

        // Reset after the high byte of a write
        wr0 = wr_cnt;
        send_byte(8'h80, 0); send_byte(8'h55, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, cmd_ready}, 32'd0);
        check("mid_rst_wrdata", {16'h0, wrData}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_wrcnt", wr_cnt - wr0, 32'd0);
        check("mid_rst_ready_back", {31'h0, cmd_ready}, 32'd1);
        send_byte(8'h80, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
        repeat (2) @(negedge clk);
        check("post_rst_wrcnt", wr_cnt - wr0, 32'd1);
        read4(8'h00, 32'h77887788, "rd_0_0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
